// File: rtl/pwm_peripheral_pkg.sv
// pwm_pkg: shared constants and helpers for the PWM peripheral.
//   PWM_CNT_W        - PWM counter / duty width
//   DUTY_FULL        - duty code meaning "always on"
//   PRESCALE_DEFAULT - default clk cycles per PWM counter step
//   prescale_width() - width of the prescaler counter for a given PRESCALE
package pwm_pkg;

  localparam int unsigned PWM_CNT_W        = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int unsigned PRESCALE_DEFAULT = 13;

  // Prescaler counts 0..prescale-1; at least one bit even when prescale==1.
  function automatic int unsigned prescale_width(input int unsigned prescale);
    int unsigned w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if: configuration register bundle from the SPI register block.
//   en_reg_out_7_0  / en_reg_out_15_8 - per-pin output enable
//   en_reg_pwm_7_0  / en_reg_pwm_15_8 - per-pin PWM select (0 = static high)
//   pwm_duty_cycle                    - shared duty value
// master: register block side (drives); slave: PWM peripheral side (samples).
interface pwm_peripheral_if;

  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle
  );

  modport slave (
    input en_reg_out_7_0,
    input en_reg_out_15_8,
    input en_reg_pwm_7_0,
    input en_reg_pwm_15_8,
    input pwm_duty_cycle
  );

endinterface

// File: rtl/pwm_peripheral_timebase.sv
// pwm_timebase: prescaler, PWM period counter and period-aligned duty shadow.
//   clk, rst_n    - clock, synchronous active-low reset
//   duty_in       - duty value to capture at the start of each period
//   pwm_cnt       - PWM counter, advances once every PRESCALE clk cycles
//   duty_sh       - duty value in effect for the current period
//   period_start  - high on the first clk of each PWM period
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
  parameter int unsigned CNT_W    = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] duty_in,
  output logic [CNT_W-1:0] pwm_cnt,
  output logic [CNT_W-1:0] duty_sh,
  output logic             period_start
);

  localparam int unsigned PRE_W = prescale_width(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic             tick;

  assign tick         = (pre_cnt_q == PRE_LAST);
  assign period_start = (pre_cnt_q == '0) && (pwm_cnt_q == '0);

  always_comb begin
    pre_cnt_d = pre_cnt_q + PRE_W'(1);
    pwm_cnt_d = pwm_cnt_q;
    duty_sh_d = duty_sh_q;
    if (tick) begin
      pre_cnt_d = '0;
      pwm_cnt_d = pwm_cnt_q + CNT_W'(1);  // natural 255 -> 0 wrap
    end
    // Duty is only taken at the period boundary so mid-period writes never
    // shorten or stretch the pulse already in progress.
    if (period_start) begin
      duty_sh_d = duty_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      duty_sh_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_sh_q <= duty_sh_d;
    end
  end

  assign pwm_cnt = pwm_cnt_q;
  assign duty_sh = duty_sh_q;

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: one shared 8-bit PWM waveform fanned out to 16 pins.
//   clk, rst_n - clock, synchronous active-low reset
//   cfg        - SPI configuration registers (enable, PWM select, duty)
//   out        - registered pin drive; bit i: disabled -> 0,
//                enabled static -> 1, enabled PWM -> shared PWM signal
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
  parameter int unsigned CNT_W    = PWM_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_peripheral_if.slave     cfg,
  output logic [15:0]         out
);

  logic [CNT_W-1:0] pwm_cnt;
  logic [CNT_W-1:0] duty_sh;
  logic             period_start;
  logic             pwm_sig;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [15:0]      out_q, out_d;

  pwm_timebase #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .duty_in      (cfg.pwm_duty_cycle),
    .pwm_cnt      (pwm_cnt),
    .duty_sh      (duty_sh),
    .period_start (period_start)
  );

  assign en_out = {cfg.en_reg_out_15_8, cfg.en_reg_out_7_0};
  assign en_pwm = {cfg.en_reg_pwm_15_8, cfg.en_reg_pwm_7_0};

  // Full-scale duty is forced on so 0xFF means a true 100%, not 255/256.
  assign pwm_sig = (duty_sh == DUTY_FULL) | (pwm_cnt < duty_sh);

  always_comb begin
    out_d = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!en_out[i]) begin
        out_d[i] = 1'b0;
      end else if (!en_pwm[i]) begin
        out_d[i] = 1'b1;
      end else begin
        out_d[i] = pwm_sig;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: directed scenarios plus randomized
// configuration changes, compared every cycle against a time-based model.
module tb_pwm_peripheral;

  localparam int P      = 13;
  localparam int PERIOD = 256 * P;

  logic        clk;
  logic        rst_n;
  logic [15:0] out;

  pwm_peripheral_if cfg_if ();

  pwm_peripheral #(
    .PRESCALE (P)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg   (cfg_if.slave),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time since reset release determines counter position; the duty in force
  // is whatever was presented at the most recent period boundary.
  int          t;
  logic [7:0]  m_duty;
  logic [15:0] exp_out;
  int          exp_cnt;
  bit          exp_ps;
  bit          model_valid = 0;

  always @(posedge clk) begin
    int  pre, cnt;
    bit  sig;
    logic [15:0] eo, ep;
    eo = {cfg_if.en_reg_out_15_8, cfg_if.en_reg_out_7_0};
    ep = {cfg_if.en_reg_pwm_15_8, cfg_if.en_reg_pwm_7_0};
    if (!rst_n) begin
      t           = 0;
      m_duty      = 8'h00;
      exp_out     = 16'h0000;
      model_valid = 1;
    end else if (model_valid) begin
      pre = t % P;
      cnt = (t / P) % 256;
      sig = (m_duty == 8'hFF) || (cnt < int'(m_duty));
      for (int i = 0; i < 16; i++)
        exp_out[i] = !eo[i] ? 1'b0 : (!ep[i] ? 1'b1 : sig);
      if (pre == 0 && cnt == 0) m_duty = cfg_if.pwm_duty_cycle;
      t = (t + 1) % PERIOD;
    end
    exp_cnt = (t / P) % 256;
    exp_ps  = (t % P == 0) && (exp_cnt == 0);
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check_eq("out", out, exp_out);
      check_eq("pwm_cnt", dut.pwm_cnt, exp_cnt);
      check_eq("period_start", dut.period_start, exp_ps);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    cfg_if.en_reg_out_7_0  = eo[7:0];
    cfg_if.en_reg_out_15_8 = eo[15:8];
    cfg_if.en_reg_pwm_7_0  = ep[7:0];
    cfg_if.en_reg_pwm_15_8 = ep[15:8];
    cfg_if.pwm_duty_cycle  = d;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the DUT counter shows v; a timeout counts as a failure.
  task automatic wait_cnt(input logic [7:0] v, input string tag);
    bit found = 0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      @(negedge clk);
      if (dut.pwm_cnt == v) found = 1;
    end
    check_eq(tag, found, 1);
  endtask

  // Count cycles with all pins high and cycles with a mix of high/low pins.
  task automatic count_high(input int n, output int hi, output int mixed);
    hi = 0;
    mixed = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out == 16'hFFFF) hi++;
      else if (out != 16'h0000) mixed++;
    end
  endtask

  int hi, mixed, nz;

  initial begin
    rst_n = 1'b0;
    set_cfg(16'h0000, 16'h0000, 8'h00);
    cycles(3);
    rst_n = 1'b1;

    // 1: idle outputs stay low for two periods
    nz = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (out != 16'h0000) nz++;
    end
    check_eq("t1_quiet", nz, 0);

    // 2: static enables appear one clk after the write
    set_cfg(16'h0001, 16'h0000, 8'h80);
    @(negedge clk);
    check_eq("t2_pin0", out, 16'h0001);
    cycles(50);
    check_eq("t2_pin0_hold", out, 16'h0001);
    set_cfg(16'h8001, 16'h0000, 8'h80);
    @(negedge clk);
    check_eq("t2_pin15", out, 16'h8001);

    // 3: shared PWM on all pins
    set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
    cycles(PERIOD + 3);
    count_high(PERIOD, hi, mixed);
    check_eq("t3_hi_80", hi, 128 * P);
    check_eq("t3_mixed", mixed, 0);
    set_cfg(16'hFFFF, 16'hFFFF, 8'h00);
    cycles(PERIOD + 3);
    count_high(3 * PERIOD, hi, mixed);
    check_eq("t3_hi_00", hi, 0);
    set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
    cycles(PERIOD + 3);
    count_high(3 * PERIOD, hi, mixed);
    check_eq("t3_hi_ff", hi, 3 * PERIOD);

    // 4: mid-period duty write only affects the next period
    set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
    cycles(PERIOD + 3);
    wait_cnt(8'h40, "t4_wait40");
    set_cfg(16'hFFFF, 16'hFFFF, 8'h20);
    wait_cnt(8'h90, "t4_wait90");
    count_high(PERIOD, hi, mixed);
    check_eq("t4_hi_20", hi, 32 * P);

    // 5: select toggles follow on the next clk regardless of period phase
    set_cfg(16'h0008, 16'h0008, 8'h10);
    cycles(PERIOD + 3);
    wait_cnt(8'h04, "t5_wait04");
    set_cfg(16'h0008, 16'h0000, 8'h10);
    @(negedge clk);
    check_eq("t5_static_hi", out, 16'h0008);
    wait_cnt(8'h60, "t5_wait60");
    @(negedge clk);
    check_eq("t5_static_lo_phase", out, 16'h0008);
    set_cfg(16'h0008, 16'h0008, 8'h10);
    @(negedge clk);
    check_eq("t5_pwm_lo_phase", out, 16'h0000);
    set_cfg(16'h0008, 16'h0000, 8'h10);
    @(negedge clk);
    check_eq("t5_static_again", out, 16'h0008);

    // 6: one-clk reset mid-period restarts the period cleanly
    set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
    cycles(PERIOD + 3);
    wait_cnt(8'hA0, "t6_waitA0");
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_out", out, 16'h0000);
    check_eq("t6_rst_cnt", dut.pwm_cnt, 0);
    rst_n = 1'b1;
    // first post-reset cycle still compares against the cleared duty shadow
    count_high(PERIOD, hi, mixed);
    check_eq("t6_hi_after_rst", hi, 128 * P - 1);

    // randomized configuration changes and occasional resets
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      case ($urandom_range(0, 5))
        0:       d = 8'h00;
        1:       d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      set_cfg(16'($urandom), 16'($urandom), d);
      cycles($urandom_range(1, 900));
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        cycles($urandom_range(1, 2));
        rst_n = 1'b1;
      end
    end
    cycles(PERIOD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
